digit_entry_unit: RTL and testbench

- Parametrised multi-digit operand entry register for the calculator datapath.
- Holds NDIG digits of base RADIX, edited with a movable cursor from debounced single-cycle button pulses (up/down/left/right/clear).
- On commit, converts the digit string to binary over NDIG cycles and presents the result to the ALU through a valid/ready handshake.
- Supersedes the fixed-width per-operand digit registers; one instance per operand.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/digit_entry_unit_if.sv | 12 +
 rtl/digit_modcount.sv | 29 ++
 rtl/digit_entry_unit.sv | 125 ++++++++++++
 tb/tb_digit_entry_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry datapath.
package calc_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_EDIT = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_entry_unit_if.sv
// Result handshake between the digit entry unit and the ALU operand input.
interface digit_entry_unit_if #(parameter int BW = 27);

    logic [BW-1:0] bin_value;
    logic          bin_valid;
    logic          overflow;
    logic          out_ready;

    modport master (output bin_value, output bin_valid, output overflow, input out_ready);
    modport slave  (input bin_value, input bin_valid, input overflow, output out_ready);

endinterface

// File: rtl/digit_modcount.sv
// Single digit up/down counter modulo RADIX; wraps in both directions.
module digit_modcount
    import calc_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic               inc,
    input  logic               dec,
    input  logic               clr,
    output logic [DIGIT_W-1:0] value
);

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(RADIX - 1);

    // inc and dec together cancel out
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            value <= '0;
        end else if (en && inc && !dec) begin
            value <= (value == TOP) ? '0 : value + 1'b1;
        end else if (en && dec && !inc) begin
            value <= (value == '0) ? TOP : value - 1'b1;
        end
    end

endmodule

// File: rtl/digit_entry_unit.sv
// Multi-digit operand entry register with cursor editing and a serial
// MSD-first digit-string to binary converter feeding a valid/ready result port.
module digit_entry_unit
    import calc_pkg::*;
#(
    parameter int NDIG          = 8,
    parameter int RADIX         = 10,
    parameter int BW            = 27,
    parameter int WRAP_CURSOR   = 1,
    parameter int CLR_ON_ACCEPT = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      up,
    input  logic                      down,
    input  logic                      left,
    input  logic                      right,
    input  logic                      clr,
    input  logic                      commit,
    output logic [DIGIT_W*NDIG-1:0]   digits,
    output logic [clog2(NDIG)-1:0]    cursor,
    output logic                      busy,
    digit_entry_unit_if.master        res
);

    localparam int CW    = clog2(NDIG);
    localparam int SW    = clog2(NDIG + 1);
    localparam int ACC_W = BW + 4;
    localparam logic [CW-1:0] CMAX = CW'(NDIG - 1);

    state_t           state;
    state_t           state_nx;
    logic             edit_ok;
    logic             start;
    logic             accept;
    logic             conv_done;
    logic             clr_digits;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_step;
    logic [CW-1:0]    idx;
    logic [SW-1:0]    steps;
    logic             ovf;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_EDIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_EDIT: if (commit && !clr) state_nx = ST_CONV;
            ST_CONV: if (steps == SW'(NDIG)) state_nx = ST_HOLD;
            ST_HOLD: if (res.out_ready) state_nx = ST_EDIT;
            default: state_nx = ST_EDIT;
        endcase
    end

    // clr beats commit, and commit suppresses any edits in the same cycle
    always_comb begin
        busy          = (state != ST_EDIT);
        res.bin_valid = (state == ST_HOLD);
        edit_ok       = (state == ST_EDIT) && !clr && !commit;
        start         = (state == ST_EDIT) && !clr && commit;
        accept        = (state == ST_HOLD) && res.out_ready;
        conv_done     = (state == ST_CONV) && (steps == SW'(NDIG));
        clr_digits    = ((state == ST_EDIT) && clr) || (accept && (CLR_ON_ACCEPT != 0));
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        digit_modcount #(.RADIX(RADIX)) u_dig (
            .CLK   (CLK),
            .RST   (RST),
            .en    (cursor == CW'(i)),
            .inc   (edit_ok & up),
            .dec   (edit_ok & down),
            .clr   (clr_digits),
            .value (digits[i*DIGIT_W +: DIGIT_W])
        );
    end

    // Digit ops above see the pre-move cursor because both update on the same edge
    always_ff @(posedge CLK) begin
        if (RST || clr_digits) begin
            cursor <= '0;
        end else if (edit_ok && left && !right) begin
            if (cursor == CMAX) cursor <= (WRAP_CURSOR != 0) ? '0 : CMAX;
            else                cursor <= cursor + 1'b1;
        end else if (edit_ok && right && !left) begin
            if (cursor == '0) cursor <= (WRAP_CURSOR != 0) ? CMAX : '0;
            else              cursor <= cursor - 1'b1;
        end
    end

    assign acc_step = acc * ACC_W'(RADIX) + ACC_W'(digits[idx*DIGIT_W +: DIGIT_W]);

    // The extra CONV cycle after the last step is spent on the HOLD transition
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc   <= '0;
            idx   <= '0;
            steps <= '0;
            ovf   <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            idx   <= CMAX;
            steps <= '0;
            ovf   <= 1'b0;
        end else if ((state == ST_CONV) && !conv_done) begin
            acc   <= acc_step;
            idx   <= idx - 1'b1;
            steps <= steps + 1'b1;
            if (acc_step[ACC_W-1:BW] != '0) ovf <= 1'b1;
        end else if (accept) begin
            ovf <= 1'b0;
        end
    end

    assign res.bin_value = acc[BW-1:0];
    assign res.overflow  = ovf;

endmodule

// File: tb/tb_digit_entry_unit.sv
// Directed bench: dut_a is decimal with wrapping cursor, dut_b is hex with a
// saturating cursor and clear-on-accept; both share the same stimulus.
module tb_digit_entry_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        clr = 1'b0, commit = 1'b0, out_ready = 1'b0;
    logic [31:0] digits_a, digits_b;
    logic [2:0]  cursor_a, cursor_b;
    logic        busy_a, busy_b;
    int          checks = 0;
    int          errors = 0;

    digit_entry_unit_if #(.BW(27)) ifa ();
    digit_entry_unit_if #(.BW(27)) ifb ();

    assign ifa.out_ready = out_ready;
    assign ifb.out_ready = out_ready;

    always #5 CLK = ~CLK;

    digit_entry_unit #(.NDIG(8), .RADIX(10), .BW(27), .WRAP_CURSOR(1), .CLR_ON_ACCEPT(0)) dut_a (
        .CLK(CLK), .RST(RST), .up(up), .down(down), .left(left), .right(right),
        .clr(clr), .commit(commit), .digits(digits_a), .cursor(cursor_a), .busy(busy_a), .res(ifa)
    );

    digit_entry_unit #(.NDIG(8), .RADIX(16), .BW(27), .WRAP_CURSOR(0), .CLR_ON_ACCEPT(1)) dut_b (
        .CLK(CLK), .RST(RST), .up(up), .down(down), .left(left), .right(right),
        .clr(clr), .commit(commit), .digits(digits_b), .cursor(cursor_b), .busy(busy_b), .res(ifb)
    );

    task automatic step();
        @(posedge CLK);
        #1;
        up = 0; down = 0; left = 0; right = 0; clr = 0; commit = 0;
    endtask

    task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic c, input logic cm);
        up = u; down = d; left = l; right = r; clr = c; commit = cm;
        step();
    endtask

    task automatic do_reset();
        RST = 1; out_ready = 0;
        step();
        RST = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (digits_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_digits_a: got %h expected %h", digits_a, 32'h0); end
        checks++; if (cursor_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_cursor_a: got %0d expected 0", cursor_a); end
        checks++; if (busy_a !== 1'b0 || ifa.bin_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags_a: got busy=%b valid=%b expected 0 0", busy_a, ifa.bin_valid); end
        checks++; if (ifa.bin_value !== 27'd0 || ifa.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_a: got %h/%b expected 0/0", ifa.bin_value, ifa.overflow); end
        checks++; if (busy_b !== 1'b0 || digits_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_b: got busy=%b digits=%h expected 0 0", busy_b, digits_b); end
    endtask

    task automatic test_entry();
        do_reset();
        repeat (8) pulse(1, 0, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        repeat (3) pulse(1, 0, 0, 0, 0, 0);
        checks++; if (digits_a !== 32'h38) begin errors++; $display("[TB] FAIL entry_digits_a: got %h expected %h", digits_a, 32'h38); end
        checks++; if (cursor_a !== 3'd1) begin errors++; $display("[TB] FAIL entry_cursor_a: got %0d expected 1", cursor_a); end
        out_ready = 1;
        pulse(0, 0, 0, 0, 0, 1);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL entry_busy: got %b expected 1", busy_a); end
        for (int c = 1; c <= 9; c++) begin
            step();
            checks++; if (ifa.bin_valid !== (c == 9)) begin errors++; $display("[TB] FAIL entry_latency_c%0d: got %b expected %b", c, ifa.bin_valid, (c == 9)); end
        end
        checks++; if (ifa.bin_value !== 27'd38 || ifa.overflow !== 1'b0) begin errors++; $display("[TB] FAIL entry_value_a: got %0d/%b expected 38/0", ifa.bin_value, ifa.overflow); end
        checks++; if (ifb.bin_value !== 27'h38 || ifb.bin_valid !== 1'b1) begin errors++; $display("[TB] FAIL entry_value_b: got %h/%b expected 38/1", ifb.bin_value, ifb.bin_valid); end
        step();
        out_ready = 0;
        checks++; if (ifa.bin_valid !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL entry_return: got valid=%b busy=%b expected 0 0", ifa.bin_valid, busy_a); end
        checks++; if (digits_a !== 32'h38) begin errors++; $display("[TB] FAIL entry_keep_a: got %h expected %h", digits_a, 32'h38); end
        checks++; if (digits_b !== 32'h0 || cursor_b !== 3'd0) begin errors++; $display("[TB] FAIL entry_clr_accept_b: got %h/%0d expected 0/0", digits_b, cursor_b); end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse(0, 1, 0, 0, 0, 0);
        checks++; if (digits_a !== 32'h9) begin errors++; $display("[TB] FAIL wrap_down_a: got %h expected %h", digits_a, 32'h9); end
        checks++; if (digits_b !== 32'hF) begin errors++; $display("[TB] FAIL wrap_down_b: got %h expected %h", digits_b, 32'hF); end
        pulse(0, 0, 0, 1, 0, 0);
        checks++; if (cursor_a !== 3'd7) begin errors++; $display("[TB] FAIL wrap_right_a: got %0d expected 7", cursor_a); end
        checks++; if (cursor_b !== 3'd0) begin errors++; $display("[TB] FAIL sat_right_b: got %0d expected 0", cursor_b); end
        pulse(0, 0, 1, 0, 0, 0);
        checks++; if (cursor_a !== 3'd0 || cursor_b !== 3'd1) begin errors++; $display("[TB] FAIL wrap_left: got a=%0d b=%0d expected 0 1", cursor_a, cursor_b); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse(1, 1, 0, 0, 0, 0);
        checks++; if (digits_a !== 32'h0) begin errors++; $display("[TB] FAIL sim_updown: got %h expected %h", digits_a, 32'h0); end
        pulse(1, 0, 1, 0, 0, 0);
        checks++; if (digits_a !== 32'h1 || cursor_a !== 3'd1) begin errors++; $display("[TB] FAIL sim_upleft: got %h/%0d expected 1/1", digits_a, cursor_a); end
        pulse(0, 0, 1, 1, 0, 0);
        checks++; if (cursor_a !== 3'd1) begin errors++; $display("[TB] FAIL sim_leftright: got %0d expected 1", cursor_a); end
        pulse(0, 0, 0, 0, 1, 1);
        checks++; if (digits_a !== 32'h0 || cursor_a !== 3'd0 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL sim_clrcommit: got %h/%0d/%b expected 0/0/0", digits_a, cursor_a, busy_a); end
        step();
        checks++; if (busy_a !== 1'b0 || ifa.bin_valid !== 1'b0) begin errors++; $display("[TB] FAIL sim_noconv: got busy=%b valid=%b expected 0 0", busy_a, ifa.bin_valid); end
    endtask

    task automatic test_overflow_hold();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pulse(0, 1, 0, 0, 0, 0);
            pulse(0, 0, 1, 0, 0, 0);
        end
        checks++; if (digits_b !== 32'hFFFFFFFF || cursor_b !== 3'd7) begin errors++; $display("[TB] FAIL ovf_entry_b: got %h/%0d expected FFFFFFFF/7", digits_b, cursor_b); end
        checks++; if (digits_a !== 32'h99999999 || cursor_a !== 3'd0) begin errors++; $display("[TB] FAIL ovf_entry_a: got %h/%0d expected 99999999/0", digits_a, cursor_a); end
        pulse(0, 0, 0, 0, 0, 1);
        repeat (9) step();
        checks++; if (ifb.bin_valid !== 1'b1 || ifb.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag_b: got valid=%b ovf=%b expected 1 1", ifb.bin_valid, ifb.overflow); end
        checks++; if (ifb.bin_value !== 27'h7FFFFFF) begin errors++; $display("[TB] FAIL ovf_value_b: got %h expected %h", ifb.bin_value, 27'h7FFFFFF); end
        checks++; if (ifa.overflow !== 1'b0 || ifa.bin_value !== 27'd99999999) begin errors++; $display("[TB] FAIL ovf_value_a: got %0d/%b expected 99999999/0", ifa.bin_value, ifa.overflow); end
        for (int c = 0; c < 20; c++) begin
            pulse(c[0], 0, 0, 0, ~c[0], 0);
            checks++; if (ifa.bin_valid !== 1'b1 || ifa.bin_value !== 27'd99999999 || digits_a !== 32'h99999999) begin errors++; $display("[TB] FAIL hold_a_c%0d: got %b/%0d/%h expected 1/99999999/99999999", c, ifa.bin_valid, ifa.bin_value, digits_a); end
            checks++; if (ifb.bin_valid !== 1'b1 || ifb.overflow !== 1'b1 || digits_b !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL hold_b_c%0d: got %b/%b/%h expected 1/1/FFFFFFFF", c, ifb.bin_valid, ifb.overflow, digits_b); end
        end
        out_ready = 1;
        step();
        out_ready = 0;
        checks++; if (ifb.bin_valid !== 1'b0 || ifb.overflow !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("[TB] FAIL accept_flags_b: got %b/%b/%b expected 0/0/0", ifb.bin_valid, ifb.overflow, busy_b); end
        checks++; if (digits_b !== 32'h0 || cursor_b !== 3'd0) begin errors++; $display("[TB] FAIL accept_clr_b: got %h/%0d expected 0/0", digits_b, cursor_b); end
        checks++; if (digits_a !== 32'h99999999 || ifa.bin_valid !== 1'b0) begin errors++; $display("[TB] FAIL accept_a: got %h/%b expected 99999999/0", digits_a, ifa.bin_valid); end
    endtask

    task automatic test_reset_mid_conv();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            repeat (8 - i) pulse(1, 0, 0, 0, 0, 0);
            pulse(0, 0, 1, 0, 0, 0);
        end
        checks++; if (digits_a !== 32'h12345678) begin errors++; $display("[TB] FAIL midconv_entry: got %h expected %h", digits_a, 32'h12345678); end
        pulse(0, 0, 0, 0, 0, 1);
        step();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL midconv_busy: got %b expected 1", busy_a); end
        RST = 1;
        step();
        RST = 0;
        checks++; if (digits_a !== 32'h0 || cursor_a !== 3'd0) begin errors++; $display("[TB] FAIL midconv_digits: got %h/%0d expected 0/0", digits_a, cursor_a); end
        checks++; if (busy_a !== 1'b0 || ifa.bin_valid !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("[TB] FAIL midconv_flags: got %b/%b/%b expected 0/0/0", busy_a, ifa.bin_valid, busy_b); end
        repeat (10) step();
        checks++; if (ifa.bin_valid !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("[TB] FAIL midconv_discard: got valid=%b busy=%b expected 0 0", ifa.bin_valid, busy_a); end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_wrap();
        test_simultaneous();
        test_overflow_hold();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
